module_leds_driver: RTL and testbench
=====================================

Name: module_leds_driver

Overview:
Parametrised successor of the 4-LED binary display stage. It latches a value from the decoder path on a valid strobe and drives N active-low board LEDs. Adds global PWM brightness control and three display modes: static, blink, and chase. Sits between the decoder and the FPGA LED pins.

Parameters:
N_LEDS, 4, number of LEDs and width of the data input (1..16)
PWM_BITS, 8, width of the brightness value and of the PWM counter
BLINK_DIV, 13500000, clock cycles per blink/chase tick (>=2; 0.5 s at 27 MHz)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
binario_i  input  N_LEDS  value to display; bit i maps to LED i
valid_i  input  1  one-cycle strobe; latch binario_i
modo_i  input  2  display mode: 00 static, 01 blink, 10 chase, 11 reserved (treated as static)
brillo_i  input  PWM_BITS  brightness duty value
led_o  output  N_LEDS  LED pins, active-low (0 = lit)

Behaviour:
- One clock; reset is synchronous and active-high. All state is cleared on the rising edge of clk while rst=1.
- Reset values:
  - dato_q = 0; brillo_q = all ones; PWM counter = 0; divider = 0; fase = 1; chase one-hot = bit 0; state = ESTATICO.
  - led_o = all ones (all LEDs off).
- Data capture: dato_q <= binario_i on any edge with valid_i=1, in every mode. Otherwise dato_q holds.
- Latency: led_o is registered. A value captured at edge k appears on led_o after edge k+1.
- PWM:
  - cnt runs free over 0..2^PWM_BITS-1 and wraps to 0.
  - pwm_on = (cnt < brillo_q).
  - brillo_q <= brillo_i only on the edge where cnt = max. This makes duty changes glitch-free: a mid-period change takes effect at the next period.
  - brillo_q = 0: LEDs never lit. brillo_q = max: lit for 2^PWM_BITS-1 of every 2^PWM_BITS cycles.
- Divider:
  - Counts 0..BLINK_DIV-1, then wraps.
  - A tick is asserted for one cycle at terminal count (BLINK_DIV-1).
  - fase toggles on each tick.
- FSM states: ESTATICO, PARPADEO, BARRIDO.
  - State is selected from modo_i on every edge; a mode change takes effect on the next edge.
  - On any state change, the divider is cleared to 0 and fase is set to 1.
  - On entry to BARRIDO, the one-hot is set to bit 0.
- Pattern selected by state:
  - ESTATICO: dato_q.
  - PARPADEO: dato_q when fase=1, otherwise all zeros.
  - BARRIDO: one-hot, rotated left by one on each tick; wraps from bit N_LEDS-1 to bit 0. dato_q is ignored for display but still captured.
- Output: led_o <= ~(pattern AND replicate(pwm_on)).
- Simultaneous valid_i and mode change: both take effect; the new state displays the new dato_q.
- Reset asserted mid-operation: all state returns to its reset values on that edge. The first lit output is possible two edges after rst deasserts.

Optional Feature:
LEDS_ACTIVE_HIGH_EN
- Defined: the final inversion is removed, so led_o = pattern AND pwm_on, and the reset value of led_o is all zeros. Used for boards with active-high LEDs.
- Not defined: active-low output, exactly as specified above.

Test Plan:
The bench uses N_LEDS=4, PWM_BITS=3, BLINK_DIV=4.
- Reset, brillo_i=7, static: rst held 3 cycles -> led_o=4'b1111. Then valid_i=1 with binario_i=4'b0101 -> led_o=4'b1010 for 7 of every 8 cycles and 4'b1111 for 1 of every 8.
- Brightness: brillo_i=2 changed while cnt=3 -> old duty until wrap. Afterwards led_o low-bits lit only while cnt in {0,1}, i.e. 2/8 cycles. brillo_i=0 -> led_o=4'b1111 constantly.
- Blink: modo_i=01, dato_q=4'b1111, brillo max -> led_o alternates 4'b0000-ish (PWM-gated) and 4'b1111 every 4 cycles, starting in the lit phase.
- Chase: modo_i=10 -> lit LED sequence 0,1,2,3,0 with each step 4 cycles apart. valid_i pulses during chase do not alter the sequence. Switching back to static shows the last captured value.
- Simultaneous: valid_i=1 with binario_i=4'b0011 and modo_i 10->00 on the same edge -> after 2 edges led_o=4'b1100 (PWM-gated).
- Reset mid-blink: rst pulse during the fase=0 phase -> led_o=4'b1111 and dato_q=0. After release with valid_i binario_i=4'b1000 and modo_i=01 -> blink restarts in the lit phase.

Source files
------------

// File: rtl/module_leds_driver.sv
// module_leds_driver
//   Latches a value from the decoder path on a valid strobe and drives N board LEDs
//   with global PWM brightness and three display modes (static, blink, chase).
//
// Parameters
//   N_LEDS    number of LEDs and width of binario_i (1..16)
//   PWM_BITS  width of the brightness value and of the free-running PWM counter
//   BLINK_DIV clock cycles per blink/chase tick (>= 2)
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active-high
//   binario_i  value to display; bit i maps to LED i
//   valid_i    one-cycle strobe; latches binario_i
//   modo_i     display mode: 00 static, 01 blink, 10 chase, 11 static
//   brillo_i   brightness duty value, sampled once per PWM period
//   led_o      registered LED pins, active-low by default (0 = lit)
//
// Build option
//   LEDS_ACTIVE_HIGH_EN  when defined, led_o is active-high (1 = lit, reset value all zeros)

module module_leds_driver #(
  parameter int unsigned N_LEDS    = 4,
  parameter int unsigned PWM_BITS  = 8,
  parameter int unsigned BLINK_DIV = 13500000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_LEDS-1:0]   binario_i,
  input  logic                valid_i,
  input  logic [1:0]          modo_i,
  input  logic [PWM_BITS-1:0] brillo_i,
  output logic [N_LEDS-1:0]   led_o
);

  localparam int unsigned    DivW    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(BLINK_DIV - 1);

`ifdef LEDS_ACTIVE_HIGH_EN
  localparam logic [N_LEDS-1:0] LedOff = '0;
`else
  localparam logic [N_LEDS-1:0] LedOff = '1;
`endif

  typedef enum logic [1:0] {
    StEstatico,
    StParpadeo,
    StBarrido
  } state_e;

  state_e                state_q, state_d;
  logic [N_LEDS-1:0]     dato_q;
  logic [PWM_BITS-1:0]   brillo_q;
  logic [PWM_BITS-1:0]   cnt_q;
  logic [DivW-1:0]       div_q;
  logic                  fase_q;
  logic [N_LEDS-1:0]     onehot_q;

  logic                  tick;
  logic                  pwm_on;
  logic [N_LEDS-1:0]     onehot_rot;
  logic [N_LEDS-1:0]     pattern;
  logic [N_LEDS-1:0]     led_d;

  // Mode decode; the reserved encoding falls back to static display.
  always_comb begin
    state_d = StEstatico;
    case (modo_i)
      2'b01:   state_d = StParpadeo;
      2'b10:   state_d = StBarrido;
      default: state_d = StEstatico;
    endcase
  end

  assign tick   = (div_q == DivLast);
  assign pwm_on = (cnt_q < brillo_q);

  // Rotate left by one; written with shifts so N_LEDS = 1 stays legal.
  assign onehot_rot = (onehot_q << 1) | (onehot_q >> (N_LEDS - 1));

  always_comb begin
    pattern = dato_q;
    case (state_q)
      StParpadeo: pattern = fase_q ? dato_q : '0;
      StBarrido:  pattern = onehot_q;
      default:    pattern = dato_q;
    endcase
  end

`ifdef LEDS_ACTIVE_HIGH_EN
  assign led_d = pattern & {N_LEDS{pwm_on}};
`else
  assign led_d = ~(pattern & {N_LEDS{pwm_on}});
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StEstatico;
      dato_q   <= '0;
      brillo_q <= '1;
      cnt_q    <= '0;
      div_q    <= '0;
      fase_q   <= 1'b1;
      onehot_q <= N_LEDS'(1);
      led_o    <= LedOff;
    end else begin
      cnt_q <= cnt_q + 1'b1;
      // Brightness only changes at the period boundary so a duty update never
      // produces a truncated or stretched pulse.
      if (cnt_q == '1) begin
        brillo_q <= brillo_i;
      end

      if (valid_i) begin
        dato_q <= binario_i;
      end

      state_q <= state_d;
      if (state_d != state_q) begin
        // A mode change restarts the timebase so blink/chase start cleanly.
        div_q  <= '0;
        fase_q <= 1'b1;
        if (state_d == StBarrido) begin
          onehot_q <= N_LEDS'(1);
        end
      end else begin
        div_q <= tick ? '0 : div_q + 1'b1;
        if (tick) begin
          fase_q <= ~fase_q;
          if (state_q == StBarrido) begin
            onehot_q <= onehot_rot;
          end
        end
      end

      led_o <= led_d;
    end
  end

endmodule

// File: tb/tb_module_leds_driver.sv
// Scoreboard bench for module_leds_driver (N_LEDS=4, PWM_BITS=3, BLINK_DIV=4).
// The stimulus process pushes the hand-derived led_o value expected after each
// edge, tagged with the cycle it belongs to; the monitor pops and compares on
// the falling edge of that cycle.

module tb_module_leds_driver;

  logic       clk;
  logic       rst;
  logic [3:0] binario;
  logic       valid;
  logic [1:0] modo;
  logic [2:0] brillo;
  logic [3:0] led;

  module_leds_driver #(
    .N_LEDS   (4),
    .PWM_BITS (3),
    .BLINK_DIV(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .binario_i(binario),
    .valid_i  (valid),
    .modo_i   (modo),
    .brillo_i (brillo),
    .led_o    (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard queues (parallel).
  int         q_cyc[$];
  int         q_t[$];
  logic [3:0] q_exp[$];
  string      q_name[$];

  int n_checks = 0;
  int n_fail   = 0;
  int t        = 0;   // edges since the first reset release
  bit done     = 1'b0;
  bit reported = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
    t = t + 1;
  endtask

  task automatic chk(input logic [3:0] e, input string nm);
    q_cyc.push_back(cyc);
    q_t.push_back(t);
    q_exp.push_back(e);
    q_name.push_back(nm);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (q_cyc.size() > 0) begin
      if (q_cyc[0] <= cyc) begin
        int         ec;
        int         et;
        logic [3:0] ee;
        string      en;
        ec = q_cyc.pop_front();
        et = q_t.pop_front();
        ee = q_exp.pop_front();
        en = q_name.pop_front();
        n_checks = n_checks + 1;
        if (ec != cyc) begin
          n_fail = n_fail + 1;
          $display("FAIL %s t=%0d: sample missed (cycle %0d, now %0d)", en, et, ec, cyc);
        end else if (led !== ee) begin
          n_fail = n_fail + 1;
          $display("FAIL %s t=%0d: led_o=%b expected %b", en, et, led, ee);
        end
      end
    end
    if (done && !reported) begin
      reported = 1'b1;
      n_checks = n_checks + 1;
      if (q_cyc.size() != 0) begin
        n_fail = n_fail + 1;
        $display("FAIL scoreboard_drain: %0d entries left, expected 0", q_cyc.size());
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int         bri;
    int         k;
    logic [3:0] oh;

    rst     = 1'b1;
    valid   = 1'b0;
    binario = 4'b0000;
    modo    = 2'b00;
    brillo  = 3'd7;
    repeat (3) step();
    t = 0;
    chk(4'b1111, "reset");

    // Static, full brightness.
    rst     = 1'b0;
    valid   = 1'b1;
    binario = 4'b0101;
    step();
    chk(4'b1111, "capture_latency");
    valid = 1'b0;
    while (t < 19) begin
      step();
      chk(((t - 1) % 8 == 7) ? 4'b1111 : 4'b1010, "static_pwm");
    end

    // Duty change mid-period (cnt=3): old duty until the wrap at edge 24.
    brillo = 3'd2;
    while (t < 40) begin
      step();
      bri = (t - 1 < 24) ? 7 : 2;
      chk(((t - 1) % 8 < bri) ? 4'b1010 : 4'b1111, "duty_change");
    end

    // Brightness 0 takes effect at edge 48.
    brillo = 3'd0;
    while (t < 56) begin
      step();
      bri = (t - 1 < 48) ? 2 : 0;
      chk(((t - 1) % 8 < bri) ? 4'b1010 : 4'b1111, "duty_zero");
    end

    // Full brightness back at edge 64.
    brillo = 3'd7;
    while (t < 64) begin
      step();
      chk(4'b1111, "duty_zero_hold");
    end

    // Blink with dato=1111, starting in the lit phase.
    valid   = 1'b1;
    binario = 4'b1111;
    modo    = 2'b01;
    step();
    chk(4'b1010, "duty_restore");
    valid = 1'b0;
    while (t < 81) begin
      step();
      if ((((t - 66) / 4) % 2 == 0) && ((t - 1) % 8 != 7)) chk(4'b0000, "blink");
      else chk(4'b1111, "blink");
    end

    // Chase: lit LED 0,1,2,3,0 every 4 cycles; a valid pulse must not disturb it.
    modo = 2'b10;
    step();
    chk(4'b0000, "chase_entry");
    while (t < 102) begin
      step();
      k  = ((t - 83) / 4) % 4;
      oh = 4'b0001 << k;
      chk(((t - 1) % 8 == 7) ? 4'b1111 : ~oh, "chase");
      if (t == 87) begin
        valid   = 1'b1;
        binario = 4'b0110;
      end else begin
        valid = 1'b0;
      end
    end

    // Back to static shows the value captured during chase.
    modo = 2'b00;
    step();
    chk(4'b1101, "chase_last_step");
    step();
    chk(4'b1111, "static_pwm_off");
    while (t < 107) begin
      step();
      chk(4'b1001, "static_last_value");
    end

    // Simultaneous capture and mode change.
    modo = 2'b10;
    step();
    chk(4'b1001, "static_before_chase");
    step();
    chk(4'b1110, "chase_reentry");
    valid   = 1'b1;
    binario = 4'b0011;
    modo    = 2'b00;
    step();
    chk(4'b1110, "simul_prev");
    valid = 1'b0;
    step();
    chk(4'b1100, "simultaneous");
    step();
    chk(4'b1111, "simul_pwm_off");
    step();
    chk(4'b1100, "simul_hold");

    // Blink, then reset during the dark phase.
    modo = 2'b01;
    while (t < 118) begin
      step();
      chk(4'b1100, "blink2_lit");
    end
    step();
    chk(4'b1111, "blink2_dark");
    rst = 1'b1;
    step();
    chk(4'b1111, "reset_mid");
    rst  = 1'b0;
    modo = 2'b00;
    step();
    chk(4'b1111, "reset_dato_zero");
    valid   = 1'b1;
    binario = 4'b1000;
    modo    = 2'b01;
    step();
    chk(4'b1111, "reset_dato_zero2");
    valid = 1'b0;
    while (t < 134) begin
      step();
      if ((((t - 123) / 4) % 2 == 0) && ((t - 121) % 8 != 7)) chk(4'b0111, "blink_restart");
      else chk(4'b1111, "blink_restart");
    end

    done = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
